// File: rtl/sdram_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : sdram_port_arbiter_pkg                                      |
// | Description: Shared state encodings and width helper for the arbiter.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package sdram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUSY = 2'b01,
    ARB_DONE = 2'b10
  } arb_state_t;

  // Index width for a port count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : sdram_port_arbiter_if                                       |
// | Description: Requester-side and controller-side buses of the arbiter.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS       = 4,
  parameter int FPGA_ADDR_WIDTH = 23,
  parameter int FPGA_DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                 p_req;
  logic [NUM_PORTS-1:0]                 p_wr_en;
  logic [NUM_PORTS-1:0]                 p_rd_en;
  logic [NUM_PORTS*FPGA_ADDR_WIDTH-1:0] p_addr;
  logic [NUM_PORTS*FPGA_DATA_WIDTH-1:0] p_wr_data;
  logic [NUM_PORTS-1:0]                 p_ack;
  logic [FPGA_DATA_WIDTH-1:0]           p_rd_data;
  logic                                 m_req;
  logic                                 m_wr_en;
  logic                                 m_rd_en;
  logic [FPGA_ADDR_WIDTH-1:0]           m_addr;
  logic [FPGA_DATA_WIDTH-1:0]           m_wr_data;
  logic [FPGA_DATA_WIDTH-1:0]           m_rd_data;
  logic                                 m_ack;

  // master: the arbiter, which owns the controller command bus
  modport master (
    input  p_req, p_wr_en, p_rd_en, p_addr, p_wr_data, m_rd_data, m_ack,
    output p_ack, p_rd_data, m_req, m_wr_en, m_rd_en, m_addr, m_wr_data
  );

  modport slave (
    output p_req, p_wr_en, p_rd_en, p_addr, p_wr_data, m_rd_data, m_ack,
    input  p_ack, p_rd_data, m_req, m_wr_en, m_rd_en, m_addr, m_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : sdram_port_arbiter_rr_pick                                  |
// | Description: Combinational round-robin pick starting after last_grant.   |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module sdram_port_arbiter_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_grant,
  output logic [IDX_W-1:0]     o_winner,
  output logic                 o_any_req
);

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_winner  = i_last_grant;
    o_any_req = |i_req;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      int idx;
      idx = int'(i_last_grant) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (i_req[idx]) o_winner = IDX_W'(idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : sdram_port_arbiter                                          |
// | Description: Round-robin sharing of the sdram_controller user port.      |
// |              Define SDRAM_ARB_TIMEOUT_EN to enable the ack watchdog.     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int FPGA_ADDR_WIDTH = 23,
  parameter int FPGA_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                              fpga_clk,
  input  logic                              fpga_reset,
  sdram_port_arbiter_if.master              bus,
  output logic [idx_width(NUM_PORTS)-1:0]   grant_id,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int              c_idx_w     = idx_width(NUM_PORTS);
  localparam logic [c_idx_w-1:0] c_last_port = c_idx_w'(NUM_PORTS - 1);

  arb_state_t                 r_state,        w_state_nxt;
  logic [c_idx_w-1:0]         r_last_grant,   w_last_grant_nxt;
  logic [c_idx_w-1:0]         r_grant,        w_grant_nxt;
  logic                       r_m_req,        w_m_req_nxt;
  logic                       r_m_wr_en,      w_m_wr_en_nxt;
  logic                       r_m_rd_en,      w_m_rd_en_nxt;
  logic [FPGA_ADDR_WIDTH-1:0] r_m_addr,       w_m_addr_nxt;
  logic [FPGA_DATA_WIDTH-1:0] r_m_wr_data,    w_m_wr_data_nxt;
  logic [NUM_PORTS-1:0]       r_p_ack,        w_p_ack_nxt;
  logic [FPGA_DATA_WIDTH-1:0] r_p_rd_data,    w_p_rd_data_nxt;
  logic                       r_busy,         w_busy_nxt;
  logic                       r_timeout_err,  w_timeout_err_nxt;

  logic [c_idx_w-1:0]         w_winner;
  logic                       w_any_req;
  logic                       w_sel_wr;
  logic                       w_sel_rd;
  logic [FPGA_ADDR_WIDTH-1:0] w_sel_addr;
  logic [FPGA_DATA_WIDTH-1:0] w_sel_wr_data;
  logic                       w_wdog_expired;

  sdram_port_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (c_idx_w)
  ) u_rr_pick (
    .i_req        (bus.p_req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_req    (w_any_req)
  );

  assign w_sel_wr      = bus.p_wr_en[w_winner];
  assign w_sel_rd      = bus.p_rd_en[w_winner];
  assign w_sel_addr    = bus.p_addr[int'(w_winner)*FPGA_ADDR_WIDTH +: FPGA_ADDR_WIDTH];
  assign w_sel_wr_data = bus.p_wr_data[int'(w_winner)*FPGA_DATA_WIDTH +: FPGA_DATA_WIDTH];

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int c_wdog_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_wdog_w-1:0] c_wdog_limit = c_wdog_w'(TIMEOUT_CYCLES - 1);

  logic [c_wdog_w-1:0] r_wdog_cnt;

  // Held at zero outside BUSY, so every grant starts a fresh count.
  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset)
      r_wdog_cnt <= '0;
    else if (r_state != ARB_BUSY)
      r_wdog_cnt <= '0;
    else
      r_wdog_cnt <= r_wdog_cnt + c_wdog_w'(1);
  end

  assign w_wdog_expired = (r_state == ARB_BUSY) && (r_wdog_cnt == c_wdog_limit);
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign w_wdog_expired = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_last_grant_nxt  = r_last_grant;
    w_grant_nxt       = r_grant;
    w_m_req_nxt       = r_m_req;
    w_m_wr_en_nxt     = r_m_wr_en;
    w_m_rd_en_nxt     = r_m_rd_en;
    w_m_addr_nxt      = r_m_addr;
    w_m_wr_data_nxt   = r_m_wr_data;
    w_p_ack_nxt       = '0;
    w_p_rd_data_nxt   = r_p_rd_data;
    w_timeout_err_nxt = r_timeout_err;

    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt      = w_winner;
          w_last_grant_nxt = w_winner;
          if (w_sel_wr || w_sel_rd) begin
            w_m_req_nxt     = 1'b1;
            w_m_wr_en_nxt   = w_sel_wr;
            w_m_rd_en_nxt   = ~w_sel_wr;
            w_m_addr_nxt    = w_sel_addr;
            w_m_wr_data_nxt = w_sel_wr_data;
            w_state_nxt     = ARB_BUSY;
          end else begin
            // Null op: acknowledge without touching the controller.
            w_p_ack_nxt[w_winner] = 1'b1;
            w_state_nxt           = ARB_DONE;
          end
        end
      end
      ARB_BUSY: begin
        if (bus.m_ack || w_wdog_expired) begin
          w_m_req_nxt          = 1'b0;
          w_m_wr_en_nxt        = 1'b0;
          w_m_rd_en_nxt        = 1'b0;
          w_p_ack_nxt[r_grant] = 1'b1;
          w_state_nxt          = ARB_DONE;
          if (bus.m_ack) begin
            if (r_m_rd_en) w_p_rd_data_nxt = bus.m_rd_data;
          end else begin
            w_p_rd_data_nxt   = '0;
            w_timeout_err_nxt = 1'b1;
          end
        end
      end
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ARB_IDLE);
  end

  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) begin
      r_state       <= ARB_IDLE;
      r_last_grant  <= c_last_port;
      r_grant       <= '0;
      r_m_req       <= 1'b0;
      r_m_wr_en     <= 1'b0;
      r_m_rd_en     <= 1'b0;
      r_m_addr      <= '0;
      r_m_wr_data   <= '0;
      r_p_ack       <= '0;
      r_p_rd_data   <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_grant       <= w_grant_nxt;
      r_m_req       <= w_m_req_nxt;
      r_m_wr_en     <= w_m_wr_en_nxt;
      r_m_rd_en     <= w_m_rd_en_nxt;
      r_m_addr      <= w_m_addr_nxt;
      r_m_wr_data   <= w_m_wr_data_nxt;
      r_p_ack       <= w_p_ack_nxt;
      r_p_rd_data   <= w_p_rd_data_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign bus.m_req     = r_m_req;
  assign bus.m_wr_en   = r_m_wr_en;
  assign bus.m_rd_en   = r_m_rd_en;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_wr_data = r_m_wr_data;
  assign bus.p_ack     = r_p_ack;
  assign bus.p_rd_data = r_p_rd_data;
  assign grant_id      = r_grant;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire
